sc_hit_pulse_gen: RTL and testbench

- Upstream stage of the lives counter: converts the raw frog/vehicle collision level into exactly one active-low lose-life pulse per hit.
- That pulse drives the counter's active-low upcount input.
- After each hit, enforces an invulnerability window, emits a respawn strobe, and re-arms only once the collision has cleared.
- Prevents one long overlap from charging several lives.

---
 rtl/sc_hit_pulse_gen.sv | 152 +++++++++++++++
 tb/tb_sc_hit_pulse_gen.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sc_hit_pulse_gen.sv
// -----------------------------------------------------------------------------
// sc_hit_pulse_gen
//
// Purpose:
//   Turns the raw frog/vehicle collision level into exactly one active-low
//   lose-life pulse per hit. This pulse feeds the lives counter's active-low
//   upcount input.
//   After each hit the block:
//     - holds an invulnerability window of INVULN_CYCLES enabled cycles,
//     - emits a one-cycle respawn strobe,
//     - re-arms only once the collision level has cleared.
//   As a result, one long overlap can never charge more than one life.
//
// Parameters:
//   INVULN_CYCLES  window length in enabled clock cycles (1 .. 2**CNT_WIDTH)
//   CNT_WIDTH      width of the invulnerability down-counter
//
// Ports:
//   SC_HIT_PULSE_GEN_CLOCK_50          in   system clock, rising edge
//   SC_HIT_PULSE_GEN_RESET_InLow       in   asynchronous active-low reset
//   SC_HIT_PULSE_GEN_collision_InHigh  in   raw collision level
//   SC_HIT_PULSE_GEN_enable_InHigh     in   game running; low pauses the block
//   SC_HIT_PULSE_GEN_gameover_InHigh   in   game over; blocks new hits
//   SC_HIT_PULSE_GEN_loselife_OutLow   out  one-cycle active-low lose-life pulse
//   SC_HIT_PULSE_GEN_respawn_OutHigh   out  one-cycle respawn strobe
//   SC_HIT_PULSE_GEN_invuln_OutHigh    out  high while hits are ignored
//
// Build option:
//   SC_HIT_PULSE_GEN_SYNC_EN - when defined, collision passes through a
//   two-flop synchronizer before the FSM. This adds 2 cycles of latency.
// -----------------------------------------------------------------------------
module sc_hit_pulse_gen #(
  parameter int INVULN_CYCLES = 25000000,
  parameter int CNT_WIDTH     = 25
) (
  input  logic SC_HIT_PULSE_GEN_CLOCK_50,
  input  logic SC_HIT_PULSE_GEN_RESET_InLow,
  input  logic SC_HIT_PULSE_GEN_collision_InHigh,
  input  logic SC_HIT_PULSE_GEN_enable_InHigh,
  input  logic SC_HIT_PULSE_GEN_gameover_InHigh,
  output logic SC_HIT_PULSE_GEN_loselife_OutLow,
  output logic SC_HIT_PULSE_GEN_respawn_OutHigh,
  output logic SC_HIT_PULSE_GEN_invuln_OutHigh
);

  typedef enum logic [2:0] {
    ARMED      = 3'd0,
    HIT        = 3'd1,
    INVULN     = 3'd2,
    RESPAWN    = 3'd3,
    WAIT_CLEAR = 3'd4
  } state_t;

  // The counter counts the remaining INVULN cycles down to zero, so the
  // load value is one less than the window length.
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(INVULN_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 clk;
  logic                 rst_n;
  logic                 collision;
  logic                 enable;
  logic                 gameover;

  assign clk       = SC_HIT_PULSE_GEN_CLOCK_50;
  assign rst_n     = SC_HIT_PULSE_GEN_RESET_InLow;
  assign enable    = SC_HIT_PULSE_GEN_enable_InHigh;
  assign gameover  = SC_HIT_PULSE_GEN_gameover_InHigh;

`ifdef SC_HIT_PULSE_GEN_SYNC_EN
  // Collision may come from an unrelated clock domain.
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], SC_HIT_PULSE_GEN_collision_InHigh};
    end
  end

  assign collision = sync_q[1];
`else
  assign collision = SC_HIT_PULSE_GEN_collision_InHigh;
`endif

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 loselife_q, respawn_q, invuln_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARMED: begin
        if (collision && enable && !gameover) begin
          state_d = HIT;
        end
      end
      HIT: begin
        cnt_d   = CNT_LOAD;
        state_d = INVULN;
      end
      INVULN: begin
        // Paused while enable is low; exits after the zero count has been
        // spent, so the window is exactly INVULN_CYCLES enabled cycles.
        if (enable) begin
          if (cnt_q == '0) begin
            state_d = RESPAWN;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      RESPAWN: begin
        state_d = collision ? WAIT_CLEAR : ARMED;
      end
      WAIT_CLEAR: begin
        if (!collision) begin
          state_d = ARMED;
        end
      end
      default: begin
        state_d = ARMED;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the current state and registered. They
  // therefore trail the state register by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARMED;
      cnt_q      <= '0;
      loselife_q <= 1'b1;
      respawn_q  <= 1'b0;
      invuln_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      loselife_q <= (state_q != HIT);
      respawn_q  <= (state_q == RESPAWN);
      invuln_q   <= (state_q == HIT) || (state_q == INVULN) || (state_q == RESPAWN);
    end
  end

  assign SC_HIT_PULSE_GEN_loselife_OutLow  = loselife_q;
  assign SC_HIT_PULSE_GEN_respawn_OutHigh  = respawn_q;
  assign SC_HIT_PULSE_GEN_invuln_OutHigh   = invuln_q;

endmodule

// File: tb/tb_sc_hit_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_sc_hit_pulse_gen
//
// Directed bench for sc_hit_pulse_gen.
//   - u_dut uses INVULN_CYCLES=4.
//   - u_dut1 uses INVULN_CYCLES=1 and covers the shortest window.
//
// Outputs are compared as the 3-bit pattern {loselife, respawn, invuln}:
//   100 idle    001 hit    101 invulnerable    111 respawn
// -----------------------------------------------------------------------------
module tb_sc_hit_pulse_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic coll  = 1'b0;
  logic en    = 1'b1;
  logic go    = 1'b0;

  logic ll0, rs0, iv0;
  logic ll1, rs1, iv1;

  always #5 clk = ~clk;

  sc_hit_pulse_gen #(.INVULN_CYCLES(4), .CNT_WIDTH(3)) u_dut (
    .SC_HIT_PULSE_GEN_CLOCK_50         (clk),
    .SC_HIT_PULSE_GEN_RESET_InLow      (rst_n),
    .SC_HIT_PULSE_GEN_collision_InHigh (coll),
    .SC_HIT_PULSE_GEN_enable_InHigh    (en),
    .SC_HIT_PULSE_GEN_gameover_InHigh  (go),
    .SC_HIT_PULSE_GEN_loselife_OutLow  (ll0),
    .SC_HIT_PULSE_GEN_respawn_OutHigh  (rs0),
    .SC_HIT_PULSE_GEN_invuln_OutHigh   (iv0)
  );

  sc_hit_pulse_gen #(.INVULN_CYCLES(1), .CNT_WIDTH(1)) u_dut1 (
    .SC_HIT_PULSE_GEN_CLOCK_50         (clk),
    .SC_HIT_PULSE_GEN_RESET_InLow      (rst_n),
    .SC_HIT_PULSE_GEN_collision_InHigh (coll),
    .SC_HIT_PULSE_GEN_enable_InHigh    (en),
    .SC_HIT_PULSE_GEN_gameover_InHigh  (go),
    .SC_HIT_PULSE_GEN_loselife_OutLow  (ll1),
    .SC_HIT_PULSE_GEN_respawn_OutHigh  (rs1),
    .SC_HIT_PULSE_GEN_invuln_OutHigh   (iv1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b (loselife,respawn,invuln)", tag, obs, exp);
    end else begin
      $display("ok   %s: %b", tag, obs);
    end
  endtask

  // Drive inputs on the falling edge, let the rising edge sample them,
  // then check u_dut 1 time unit later.
  task automatic step(input string tag, input logic c, input logic e, input logic g,
                      input logic [2:0] exp);
    @(negedge clk);
    coll = c; en = e; go = g;
    @(posedge clk);
    #1;
    check_eq(tag, {ll0, rs0, iv0}, exp);
  endtask

  // Same as step, but checks both u_dut and u_dut1.
  task automatic step2(input string tag, input logic c, input logic e, input logic g,
                       input logic [2:0] exp, input logic [2:0] exp1);
    step(tag, c, e, g, exp);
    check_eq({tag, "_w1"}, {ll1, rs1, iv1}, exp1);
  endtask

  initial begin
    // 1) Reset state, then 20 idle cycles.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_hold", {ll0, rs0, iv0}, 3'b100);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step($sformatf("idle%0d", i), 1'b0, 1'b1, 1'b0, 3'b100);
    end

    // 2) Single-cycle collision; both window lengths.
    step2("s_hit_edge", 1'b1, 1'b1, 1'b0, 3'b100, 3'b100);
    step2("s_hit",      1'b0, 1'b1, 1'b0, 3'b001, 3'b001);
    step2("s_inv0",     1'b0, 1'b1, 1'b0, 3'b101, 3'b101);
    step2("s_inv1",     1'b0, 1'b1, 1'b0, 3'b101, 3'b111);
    step2("s_inv2",     1'b0, 1'b1, 1'b0, 3'b101, 3'b100);
    step ("s_inv3",     1'b0, 1'b1, 1'b0, 3'b101);
    step ("s_resp",     1'b0, 1'b1, 1'b0, 3'b111);
    step ("s_armed",    1'b0, 1'b1, 1'b0, 3'b100);
    step ("s_armed2",   1'b0, 1'b1, 1'b0, 3'b100);

    // 3) Collision held for 30 cycles: one pulse, then park in WAIT_CLEAR.
    for (int i = 0; i < 30; i++) begin
      logic [2:0] e;
      if (i == 1)                e = 3'b001;
      else if (i >= 2 && i <= 5) e = 3'b101;
      else if (i == 6)           e = 3'b111;
      else                       e = 3'b100;
      step($sformatf("hold%0d", i), 1'b1, 1'b1, 1'b0, e);
    end
    step("hold_drop", 1'b0, 1'b1, 1'b0, 3'b100);
    step("hold_rise", 1'b1, 1'b1, 1'b0, 3'b100);
    step("hold_hit2", 1'b0, 1'b1, 1'b0, 3'b001);
    for (int i = 0; i < 4; i++) begin
      step($sformatf("hold_inv%0d", i), 1'b0, 1'b1, 1'b0, 3'b101);
    end
    step("hold_resp", 1'b0, 1'b1, 1'b0, 3'b111);
    step("hold_arm",  1'b0, 1'b1, 1'b0, 3'b100);

    // 4) Enable low for 3 cycles mid-window; collisions in the window are
    //    ignored.
    step("p_edge",  1'b1, 1'b1, 1'b0, 3'b100);
    step("p_hit",   1'b0, 1'b1, 1'b0, 3'b001);
    step("p_inv0",  1'b0, 1'b1, 1'b0, 3'b101);
    step("p_paus0", 1'b0, 1'b0, 1'b0, 3'b101);
    step("p_paus1", 1'b1, 1'b0, 1'b0, 3'b101);
    step("p_paus2", 1'b0, 1'b0, 1'b0, 3'b101);
    step("p_inv1",  1'b1, 1'b1, 1'b0, 3'b101);
    step("p_inv2",  1'b0, 1'b1, 1'b0, 3'b101);
    step("p_inv3",  1'b0, 1'b1, 1'b0, 3'b101);
    step("p_resp",  1'b0, 1'b1, 1'b0, 3'b111);
    step("p_arm",   1'b0, 1'b1, 1'b0, 3'b100);
    step("p_arm2",  1'b0, 1'b1, 1'b0, 3'b100);

    // 5) Gameover blocks new hits but not an ongoing window.
    step("g_blk0", 1'b1, 1'b1, 1'b1, 3'b100);
    step("g_blk1", 1'b0, 1'b1, 1'b1, 3'b100);
    step("g_blk2", 1'b0, 1'b1, 1'b0, 3'b100);
    step("g_edge", 1'b1, 1'b1, 1'b0, 3'b100);
    step("g_hit",  1'b0, 1'b1, 1'b0, 3'b001);
    for (int i = 0; i < 4; i++) begin
      step($sformatf("g_inv%0d", i), 1'b0, 1'b1, 1'b1, 3'b101);
    end
    step("g_resp", 1'b0, 1'b1, 1'b1, 3'b111);
    step("g_arm",  1'b1, 1'b1, 1'b1, 3'b100);
    step("g_arm2", 1'b0, 1'b1, 1'b0, 3'b100);

    // 6) Asynchronous reset mid-window, then a fresh hit.
    step("r_edge", 1'b1, 1'b1, 1'b0, 3'b100);
    step("r_hit",  1'b0, 1'b1, 1'b0, 3'b001);
    step("r_inv0", 1'b0, 1'b1, 1'b0, 3'b101);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("r_async", {ll0, rs0, iv0}, 3'b100);
    @(negedge clk);
    rst_n = 1'b1;
    step("r_idle0", 1'b0, 1'b1, 1'b0, 3'b100);
    step("r_idle1", 1'b0, 1'b1, 1'b0, 3'b100);
    step("r_edge2", 1'b1, 1'b1, 1'b0, 3'b100);
    step("r_hit2",  1'b0, 1'b1, 1'b0, 3'b001);
    for (int i = 0; i < 4; i++) begin
      step($sformatf("r_inv%0d", i + 10), 1'b0, 1'b1, 1'b0, 3'b101);
    end
    step("r_resp", 1'b0, 1'b1, 1'b0, 3'b111);
    step("r_arm",  1'b0, 1'b1, 1'b0, 3'b100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
